// File: rtl/dm_store_bank_if.sv
// ---------------------------------------------------------------------------
// dm_store_bank_if
//   Bundles the store/load bus between the datapath (master) and the data
//   memory bank (slave).
//
//   master -> slave : pc, mem_we, addr, memdata, store_sel
//   slave -> master : rdata, byte_en, align_err, err_pc
// ---------------------------------------------------------------------------
interface dm_store_bank_if;
  logic [31:0] pc;
  logic        mem_we;
  logic [31:0] addr;
  logic [31:0] memdata;
  logic [1:0]  store_sel;
  logic [31:0] rdata;
  logic [3:0]  byte_en;
  logic        align_err;
  logic [31:0] err_pc;

  modport master (
    output pc, mem_we, addr, memdata, store_sel,
    input  rdata, byte_en, align_err, err_pc
  );

  modport slave (
    input  pc, mem_we, addr, memdata, store_sel,
    output rdata, byte_en, align_err, err_pc
  );
endinterface

// File: rtl/dm_store_bank.sv
// ---------------------------------------------------------------------------
// dm_store_bank
//   Data memory bank for the single-cycle MIPS datapath. Takes the
//   lane-aligned store word, decodes per-byte enables from store size and
//   address, and commits only the selected lanes on the rising edge.
//   Reads are combinational and return the pre-write contents during a
//   write cycle. Misaligned, reserved-size and out-of-range stores are
//   dropped and flagged through a registered one-cycle align_err plus the
//   faulting PC in err_pc.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; clears the whole array and error state
//   bus    - dm_store_bank_if.slave (pc, mem_we, addr, memdata, store_sel in;
//            rdata, byte_en, align_err, err_pc out)
//
// Parameters:
//   DEPTH_LOG2 - word-address width (2**DEPTH_LOG2 words of 32 bits)
//   BASE_ADDR  - byte address mapped to word 0
//
// Optional feature:
//   DM_WRITE_LOG_EN - when defined, every committed store prints
//   "@<pc>: *<word-aligned addr> <= <merged word>" at the clock edge.
// ---------------------------------------------------------------------------
module dm_store_bank #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  dm_store_bank_if.slave  bus
);

  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
  // Byte span of the array; 33 bits so the bound itself never wraps.
  localparam logic [32:0] SPAN  = 33'(4) << DEPTH_LOG2;

  typedef enum logic [1:0] {
    SEL_SW  = 2'b00,
    SEL_SH  = 2'b01,
    SEL_SB  = 2'b10,
    SEL_RSV = 2'b11
  } store_sel_e;

  logic [31:0]           mem_q [WORDS];
  logic                  align_err_q, align_err_d;
  logic [31:0]           err_pc_q, err_pc_d;

  logic [31:0]           offs;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            off;
  logic [3:0]            lanes;
  logic                  fault;
  logic                  wr_en_d;
  logic [31:0]           wr_word_d;
  logic [31:0]           old_word;
  store_sel_e            sel;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    offs      = bus.addr - BASE_ADDR;
    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    in_range  = ({1'b0, offs} < SPAN);
    idx       = offs[DEPTH_LOG2+1:2];
    off       = bus.addr[1:0];
    sel       = store_sel_e'(bus.store_sel);
    old_word  = in_range ? mem_q[idx] : 32'h0;

    lanes = 4'b0000;
    fault = 1'b0;
    unique case (sel)
      SEL_SW:  begin
        lanes = 4'b1111;
        fault = (off != 2'b00);
      end
      SEL_SH:  begin
        lanes = off[1] ? 4'b1100 : 4'b0011;
        fault = off[0];
      end
      SEL_SB:  lanes = 4'b0001 << off;
      SEL_RSV: fault = 1'b1;
      default: ;
    endcase
    // Faults only exist for an actual store; a plain read shows the decode.
    fault = bus.mem_we && (fault || !in_range);

    wr_en_d   = bus.mem_we && !fault;
    wr_word_d = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) wr_word_d[8*i +: 8] = bus.memdata[8*i +: 8];
    end

    align_err_d = fault;
    err_pc_d    = fault ? bus.pc : err_pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what gives read-old-on-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is cleared by reset in a single edge; this rules out
      // a block-RAM mapping but matches the required power-on contents.
      for (int i = 0; i < WORDS; i++) mem_q[i] <= 32'h0;
      align_err_q <= 1'b0;
      err_pc_q    <= 32'h0;
    end else begin
      align_err_q <= align_err_d;
      err_pc_q    <= err_pc_d;
      if (wr_en_d) begin
        mem_q[idx] <= wr_word_d;
`ifdef DM_WRITE_LOG_EN
        $display("@%08h: *%08h <= %08h", bus.pc, {bus.addr[31:2], 2'b00}, wr_word_d);
`endif
      end
    end
  end

  assign bus.rdata     = old_word;
  assign bus.byte_en   = fault ? 4'b0000 : lanes;
  assign bus.align_err = align_err_q;
  assign bus.err_pc    = err_pc_q;

endmodule

// File: tb/tb_dm_store_bank.sv
module tb_dm_store_bank;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned BYTES = 4096;

  logic clk = 1'b0;
  logic reset;

  dm_store_bank_if bus ();

  dm_store_bank #(.DEPTH_LOG2(10), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        aerr;
    logic [31:0] epc;
    string       tag;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a flat byte-addressable memory plus error registers.
  byte unsigned m_mem [BYTES];
  logic         m_aerr;
  logic [31:0]  m_epc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    int unsigned w;
    o = a - BASE;
    if (o >= BYTES) return 32'h0;
    w = o & ~32'd3;
    return {m_mem[w+3], m_mem[w+2], m_mem[w+1], m_mem[w]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) m_mem[i] = 8'h00;
    m_aerr = 1'b0;
    m_epc  = 32'h0;
  endtask

  // One clock of stimulus: drive, predict, push expectation, advance model.
  task automatic step(input logic r, input logic we, input logic [1:0] sel,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] p, input string tag);
    exp_t        e;
    int unsigned size, off, start;
    logic [3:0]  lanes;
    logic [31:0] o;
    logic        fault;
    @(posedge clk);
    #1;
    reset         = r;
    bus.mem_we    = we;
    bus.store_sel = sel;
    bus.addr      = a;
    bus.memdata   = d;
    bus.pc        = p;

    size  = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : 1;
    off   = a % 4;
    start = off - (off % size);
    lanes = (sel == 2'd3) ? 4'b0000 : 4'(((1 << size) - 1) << start);
    o     = a - BASE;
    fault = we && ((sel == 2'd3) || (off % size != 0) || (o >= BYTES));

    e.rdata = model_read(a);
    e.be    = fault ? 4'b0000 : lanes;
    e.aerr  = m_aerr;
    e.epc   = m_epc;
    e.tag   = tag;
    sb.push_back(e);

    if (r) begin
      model_clear();
    end else begin
      m_aerr = fault;
      if (fault) m_epc = p;
      if (we && !fault) begin
        for (int i = 0; i < 4; i++)
          if (lanes[i]) m_mem[(o & ~32'd3) + i] = d[8*i +: 8];
      end
    end
  endtask

  // Monitor: compare what the DUT presents mid-cycle with the queued prediction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".rdata"},     bus.rdata,            e.rdata);
      check({e.tag, ".byte_en"},   32'(bus.byte_en),     32'(e.be));
      check({e.tag, ".align_err"}, 32'(bus.align_err),   32'(e.aerr));
      check({e.tag, ".err_pc"},    bus.err_pc,           e.epc);
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sel;

    reset         = 1'b1;
    bus.mem_we    = 1'b0;
    bus.store_sel = 2'b00;
    bus.addr      = 32'h0;
    bus.memdata   = 32'h0;
    bus.pc        = 32'h0;
    model_clear();
    repeat (2) @(posedge clk);

    step(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, "reset_state");
    step(0, 1, 2'b00, 32'h4, 32'h1234_5678, 32'h3000, "sw_4");
    step(0, 0, 2'b00, 32'h4, 32'h0, 32'h3004, "rd_4");
    step(0, 1, 2'b00, 32'h8, 32'hAABB_CCDD, 32'h3008, "sw_8");
    step(0, 1, 2'b10, 32'hA, 32'h0077_0000, 32'h300C, "sb_a");
    step(0, 0, 2'b00, 32'h8, 32'h0, 32'h3010, "rd_8");
    step(0, 1, 2'b01, 32'hE, 32'hBEEF_0000, 32'h3014, "sh_e");
    step(0, 0, 2'b00, 32'hC, 32'h0, 32'h3018, "rd_c");
    step(0, 1, 2'b00, 32'h6, 32'h5555_5555, 32'h3010, "sw_mis");
    step(0, 0, 2'b00, 32'h4, 32'h0, 32'h0, "err_hi");
    step(0, 0, 2'b00, 32'h4, 32'h0, 32'h0, "err_lo");
    step(0, 1, 2'b11, 32'h10, 32'h1111_1111, 32'h3020, "rsv");
    step(0, 1, 2'b00, 32'h10, 32'hCAFE_F00D, 32'h3024, "sw_after_rsv");
    step(0, 0, 2'b00, 32'h10, 32'h0, 32'h0, "rd_10");
    step(0, 1, 2'b01, 32'h13, 32'h2222_2222, 32'h3028, "sh_odd");
    step(0, 1, 2'b00, 32'h1000, 32'h3333_3333, 32'h3030, "sw_oor");
    step(0, 0, 2'b00, 32'h2000, 32'h0, 32'h0, "rd_oor");
    step(0, 1, 2'b10, 32'hFFF, 32'h4400_0000, 32'h3034, "sb_top");
    step(0, 0, 2'b00, 32'hFFC, 32'h0, 32'h0, "rd_top");

    for (int n = 0; n < 400; n++) begin
      case ($urandom % 4)
        0:       a = $urandom_range(0, 63);
        1:       a = $urandom_range(4080, 4111);
        2:       a = $urandom;
        default: a = $urandom_range(0, 4095);
      endcase
      d   = $urandom;
      sel = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      step(($urandom % 60) == 0, ($urandom % 4) != 0, sel, a, d, $urandom, "rand");
    end

    step(0, 1, 2'b00, 32'h0, 32'h0BAD_F00D, 32'h4000, "pre_rst_wr");
    step(0, 1, 2'b00, 32'h2, 32'h0, 32'h4004, "pre_rst_err");
    step(1, 1, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h4008, "rst_with_sw");
    step(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, "post_rst_0");
    step(0, 0, 2'b00, 32'h4, 32'h0, 32'h0, "post_rst_4");
    step(0, 0, 2'b00, 32'h8, 32'h0, 32'h0, "post_rst_8");
    step(0, 0, 2'b00, 32'hFFC, 32'h0, 32'h0, "post_rst_ffc");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
